// File: rtl/bsg_clk_mon_pkg.sv
// Shared types and constants for the multi-channel clock monitor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bsg_clk_mon_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        MON_IDLE    = 2'd0,
        MON_SETTLE  = 2'd1,
        MON_MEASURE = 2'd2,
        MON_DONE    = 2'd3
    } mon_state_e;

    // Widest per-channel counter the result struct can carry.
    localparam int unsigned MaxCountWidth = 32;

    // Per-channel measurement result. The count field is sized for the widest
    // supported counter; narrower instances zero-extend into it.
    typedef struct packed {
        logic                     overflow;
        logic [MaxCountWidth-1:0] count;
    } chan_result_t;

    // SETTLE must outlast the synchronizer plus the edge-detect flop so that
    // nothing sampled before the start is still in flight when MEASURE opens.
    function automatic int unsigned settle_len(input int unsigned sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/bsg_clk_mon_chan.sv
// One monitor channel: synchronizer, rising-edge detector, saturating counter.
// Latency: a toggle rise is seen by the counter sync_stages_p cycles later.
// Backpressure: none; counts only while count_en_i, holds otherwise.
//
// Ports:
//   clk_i, reset_n_i  reference clock, async active-low reset
//   toggle_i          asynchronous monitored clock
//   clear_i           zero count and overflow (takes priority)
//   count_en_i        count detected edges this cycle
//   res_o             {overflow, zero-extended count}
module bsg_clk_mon_chan
    import bsg_clk_mon_pkg::*;
#(
    parameter int unsigned count_width_p = 16,
    parameter int unsigned sync_stages_p = 2
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         toggle_i,
    input  logic         clear_i,
    input  logic         count_en_i,
    output chan_result_t res_o
);

    localparam logic [count_width_p-1:0] CountMax = '1;
    localparam logic [count_width_p-1:0] CountOne = count_width_p'(1);

    logic [sync_stages_p-1:0] sync_q, sync_d;
    logic                     prev_q;
    logic                     edge_det;
    logic [count_width_p-1:0] cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;

    // toggle enters at bit 0 and leaves the synchronizer at the MSB
    assign sync_d   = {sync_q[sync_stages_p-2:0], toggle_i};
    assign edge_det = sync_q[sync_stages_p-1] & ~prev_q;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (count_en_i && edge_det) begin
            // overflow marks an edge that arrived with the counter already full
            if (cnt_q == CountMax) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CountOne;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[sync_stages_p-1];
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign res_o.overflow = ovf_q;
    assign res_o.count    = MaxCountWidth'(cnt_q);

endmodule

// File: rtl/bsg_clk_mon_multi.sv
// Multi-channel clock monitor: counts rising edges of each toggle_i over a window.
// Latency: v_o rises sync_stages_p+1+window+1 cycles after the start-accept cycle.
// Backpressure: results held in DONE until yumi_i; new starts ignored while busy.
//
// Ports:
//   clk_i, reset_n_i           reference clock, async active-low reset
//   start_i, window_i,         start request, window length (cycles) and channel
//   chan_en_i                  enables, all sampled when the start is accepted
//   toggle_i                   asynchronous monitored clocks, one per channel
//   busy_o, v_o, yumi_i        busy outside IDLE; results valid / consumed
//   count_o, overflow_o        per-channel counts (ch0 in LSBs) and saturation flags
//   min_i, max_i, fail_o       only with BSG_CLK_MON_THRESH_EN: per-channel range check
module bsg_clk_mon_multi
    import bsg_clk_mon_pkg::*;
#(
    parameter int unsigned num_chan_p     = 4,
    parameter int unsigned count_width_p  = 16,
    parameter int unsigned window_width_p = 20,
    parameter int unsigned sync_stages_p  = 2
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                start_i,
    input  logic [window_width_p-1:0]           window_i,
    input  logic [num_chan_p-1:0]               chan_en_i,
    input  logic [num_chan_p-1:0]               toggle_i,
    output logic                                busy_o,
    output logic                                v_o,
    input  logic                                yumi_i,
    output logic [num_chan_p*count_width_p-1:0] count_o,
    output logic [num_chan_p-1:0]               overflow_o
`ifdef BSG_CLK_MON_THRESH_EN
    ,
    input  logic [count_width_p-1:0]            min_i,
    input  logic [count_width_p-1:0]            max_i,
    output logic [num_chan_p-1:0]               fail_o
`endif
);

    localparam int unsigned                SettleLen  = settle_len(sync_stages_p);
    localparam logic [window_width_p-1:0]  SettleLoad = window_width_p'(SettleLen - 1);
    localparam logic [window_width_p-1:0]  TimerOne   = window_width_p'(1);

    mon_state_e                state_q, state_d;
    logic [window_width_p-1:0] window_q, window_d;
    logic [window_width_p-1:0] timer_q, timer_d;
    logic [num_chan_p-1:0]     chan_en_q, chan_en_d;
    logic                      accept;
    logic                      measure;

    // timer_q counts the remaining cycles of the current SETTLE or MEASURE phase
    always_comb begin
        state_d   = state_q;
        window_d  = window_q;
        timer_d   = timer_q;
        chan_en_d = chan_en_q;
        accept    = 1'b0;
        case (state_q)
            MON_IDLE: begin
                if (start_i && (window_i != '0)) begin
                    accept    = 1'b1;
                    state_d   = MON_SETTLE;
                    window_d  = window_i;
                    chan_en_d = chan_en_i;
                    timer_d   = SettleLoad;
                end
            end
            MON_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = MON_MEASURE;
                    timer_d = window_q - TimerOne;
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end
            MON_MEASURE: begin
                if (timer_q == '0) begin
                    state_d = MON_DONE;
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end
            MON_DONE: begin
                if (yumi_i) begin
                    state_d = MON_IDLE;
                end
            end
            default: begin
                state_d = MON_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= MON_IDLE;
            window_q  <= '0;
            timer_q   <= '0;
            chan_en_q <= '0;
        end else begin
            state_q   <= state_d;
            window_q  <= window_d;
            timer_q   <= timer_d;
            chan_en_q <= chan_en_d;
        end
    end

    assign busy_o  = (state_q != MON_IDLE);
    assign v_o     = (state_q == MON_DONE);
    assign measure = (state_q == MON_MEASURE);

    chan_result_t res [num_chan_p];

    for (genvar i = 0; i < num_chan_p; i++) begin : g_chan
        logic [count_width_p-1:0] cnt_w;

        // counters clear on the accept edge, so disabled channels read 0
        bsg_clk_mon_chan #(
            .count_width_p (count_width_p),
            .sync_stages_p (sync_stages_p)
        ) u_chan (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
            .toggle_i   (toggle_i[i]),
            .clear_i    (accept),
            .count_en_i (measure & chan_en_q[i]),
            .res_o      (res[i])
        );

        assign cnt_w = res[i].count[count_width_p-1:0];
        assign count_o[i*count_width_p +: count_width_p] = cnt_w;

        // bits above the configured width are never set by the channel; folding
        // them into overflow keeps any such corruption visible
        if (count_width_p < MaxCountWidth) begin : g_hi
            assign overflow_o[i] = res[i].overflow
                                 | (|res[i].count[MaxCountWidth-1:count_width_p]);
        end else begin : g_full
            assign overflow_o[i] = res[i].overflow;
        end

`ifdef BSG_CLK_MON_THRESH_EN
        assign fail_o[i] = chan_en_q[i]
                         & (overflow_o[i] | (cnt_w < min_i) | (cnt_w > max_i));
`endif
    end

endmodule
